// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, IF/ID register, RUN/HALT/FAULT control
module inst_fetch #(
  parameter int unsigned MEM_BYTES = 1156,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] NOP_INST  = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_pc,
  output logic        mem_stall,
  input  logic [31:0] mem_inst,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] id_inst_n, id_pc_n, fetch_count_n, fetch_count_inc;
  logic        id_valid_n;
  logic        redirect_ok, last_word;

  // 33-bit compares so targets near 2^32 cannot wrap into range
  assign redirect_ok     = (redirect_pc[1:0] == 2'b00) &&
                           (({1'b0, redirect_pc} + 33'd4) <= MEM_LIMIT);
  assign last_word       = (({1'b0, pc} + 33'd8) > MEM_LIMIT);
  assign fetch_count_inc = (fetch_count == 32'hFFFF_FFFF) ? fetch_count : fetch_count + 32'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      id_inst     <= NOP_INST;
      id_pc       <= 32'h0;
      id_valid    <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      id_inst     <= id_inst_n;
      id_pc       <= id_pc_n;
      id_valid    <= id_valid_n;
      fetch_count <= fetch_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    id_inst_n     = id_inst;
    id_pc_n       = id_pc;
    id_valid_n    = id_valid;
    fetch_count_n = fetch_count;
    case (state)
      ST_RUN: begin
        if (redirect) begin
          if (redirect_ok) begin
            pc_n       = redirect_pc;
            id_inst_n  = NOP_INST;
            id_pc_n    = 32'h0;
            id_valid_n = 1'b0;
          end else begin
            state_n = ST_FAULT;
          end
        end else if (!stall) begin
          id_inst_n     = mem_inst;
          id_pc_n       = pc;
          id_valid_n    = 1'b1;
          fetch_count_n = fetch_count_inc;
          // the word at pc is the last one that fits; park here instead of advancing
          if (last_word) state_n = ST_HALT;
          else           pc_n    = pc + 32'd4;
        end
      end
      ST_HALT: begin
        if (redirect) begin
          if (redirect_ok) begin
            state_n    = ST_RUN;
            pc_n       = redirect_pc;
            id_inst_n  = NOP_INST;
            id_pc_n    = 32'h0;
            id_valid_n = 1'b0;
          end else begin
            state_n = ST_FAULT;
          end
        end else if (!stall) begin
          id_inst_n  = NOP_INST;
          id_pc_n    = 32'h0;
          id_valid_n = 1'b0;
        end
      end
      default: begin
        state_n    = ST_FAULT;
        id_inst_n  = NOP_INST;
        id_pc_n    = 32'h0;
        id_valid_n = 1'b0;
      end
    endcase
  end

  assign mem_pc    = pc;
  assign mem_stall = stall || (state != ST_RUN);
  assign halted    = (state == ST_HALT);
  assign fault     = (state == ST_FAULT);

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch
module tb_inst_fetch;

  localparam int          MEMB = 1156;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] mem_pc, mem_inst, id_inst, id_pc, fetch_count;
  logic        mem_stall, id_valid, halted, fault;

  inst_fetch dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_pc(mem_pc), .mem_stall(mem_stall),
    .mem_inst(mem_inst), .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] byte_at(input int a);
    return 8'((a * 13 + 5) & 255);
  endfunction

  function automatic logic [31:0] word_at(input int a);
    return {byte_at(a), byte_at(a + 1), byte_at(a + 2), byte_at(a + 3)};
  endfunction

  always_comb begin
    mem_inst = 32'h0;
    if (!mem_stall && mem_pc <= 32'(MEMB - 4)) mem_inst = word_at(int'(mem_pc));
  end

  typedef struct {
    logic [31:0] pc, inst, idpc, fc;
    logic        ck_idpc, v, h, f, ms;
  } exp_t;

  exp_t q[$];
  event async_ev;
  int n_pass = 0, n_total = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] idpc, input logic ck, input logic v,
                              input logic [31:0] fc, input logic h, input logic f,
                              input logic ms);
    exp_t e;
    e.pc = pc; e.inst = inst; e.idpc = idpc; e.ck_idpc = ck; e.v = v;
    e.fc = fc; e.h = h; e.f = f; e.ms = ms;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // monitor: compares DUT outputs after each edge, or right after an async reset
  initial begin
    exp_t e;
    forever begin
      @(posedge clock or async_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("mem_pc", mem_pc, e.pc);
        check("id_inst", id_inst, e.inst);
        if (e.ck_idpc) check("id_pc", id_pc, e.idpc);
        check("id_valid", 32'(id_valid), 32'(e.v));
        check("fetch_count", fetch_count, e.fc);
        check("halted", 32'(halted), 32'(e.h));
        check("fault", 32'(fault), 32'(e.f));
        check("mem_stall", 32'(mem_stall), 32'(e.ms));
      end
    end
  end

  task automatic step(input logic s, input logic r, input logic [31:0] rpc, input exp_t e);
    stall = s; redirect = r; redirect_pc = rpc;
    q.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic reset_check();
    stall = 1'b0; redirect = 1'b0;
    #1 reset = 1'b1;
    q.push_back(mk(32'h0, NOP, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
    -> async_ev;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    reset_check();

    // sequential fetch, redirect, stall hold and release
    step(0, 0, 0,     mk(4,     word_at(0),    0,    1, 1, 1, 0, 0, 0));
    step(0, 0, 0,     mk(8,     word_at(4),    4,    1, 1, 2, 0, 0, 0));
    step(0, 0, 0,     mk(12,    word_at(8),    8,    1, 1, 3, 0, 0, 0));
    step(0, 1, 8,     mk(8,     NOP,           0,    1, 0, 3, 0, 0, 0));
    step(1, 0, 0,     mk(8,     NOP,           0,    1, 0, 3, 0, 0, 1));
    step(1, 0, 0,     mk(8,     NOP,           0,    1, 0, 3, 0, 0, 1));
    step(0, 0, 0,     mk(12,    word_at(8),    8,    1, 1, 4, 0, 0, 0));
    // redirect wins over stall
    step(1, 1, 32'h40, mk(32'h40, NOP,         0,    1, 0, 4, 0, 0, 1));
    step(0, 0, 0,     mk(32'h44, word_at(32'h40), 32'h40, 1, 1, 5, 0, 0, 0));
    // misaligned target faults and is sticky
    step(0, 1, 32'h42, mk(32'h44, word_at(32'h40), 32'h40, 1, 1, 5, 0, 1, 1));
    step(0, 1, 0,     mk(32'h44, NOP,          0,    0, 0, 5, 0, 1, 1));
    step(0, 0, 0,     mk(32'h44, NOP,          0,    0, 0, 5, 0, 1, 1));
    reset_check();
    // out-of-range target faults
    step(0, 1, 1156,  mk(0,     NOP,           0,    1, 0, 0, 0, 1, 1));
    reset_check();
    // run off the end of memory into HALT
    step(0, 1, 1148,  mk(1148,  NOP,           0,    1, 0, 0, 0, 0, 0));
    step(0, 0, 0,     mk(1152,  word_at(1148), 1148, 1, 1, 1, 0, 0, 0));
    step(0, 0, 0,     mk(1152,  word_at(1152), 1152, 1, 1, 2, 1, 0, 1));
    step(0, 0, 0,     mk(1152,  NOP,           0,    0, 0, 2, 1, 0, 1));
    step(0, 1, 0,     mk(0,     NOP,           0,    1, 0, 2, 0, 0, 0));
    step(0, 0, 0,     mk(4,     word_at(0),    0,    1, 1, 3, 0, 0, 0));
    // last legal target, then invalid redirect out of HALT
    step(0, 1, 1152,  mk(1152,  NOP,           0,    1, 0, 3, 0, 0, 0));
    step(0, 0, 0,     mk(1152,  word_at(1152), 1152, 1, 1, 4, 1, 0, 1));
    step(0, 1, 1156,  mk(1152,  word_at(1152), 1152, 1, 1, 4, 0, 1, 1));
    reset_check();
    // reset asynchronously while running at pc=0x20
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, mk(32'(4 * (i + 1)), word_at(4 * i), 32'(4 * i), 1, 1, 32'(i + 1), 0, 0, 0));
    reset_check();
    step(0, 0, 0,     mk(4,     word_at(0),    0,    1, 1, 1, 0, 0, 0));

    repeat (3) @(negedge clock);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
